// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges a single-cycle result stream (A) and a long-latency
// result stream (B) into one registered register-file write port, with a busy scoreboard.
module writeback_arbiter #(
  parameter int XLEN       = 32,
  parameter int N_REG      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_iss_valid,
  input  logic [4:0]       i_iss_rd,
  output logic             o_iss_ready,
  input  logic             i_a_valid,
  input  logic [4:0]       i_a_rd,
  input  logic [XLEN-1:0]  i_a_data,
  output logic             o_a_ready,
  input  logic             i_b_valid,
  input  logic [4:0]       i_b_rd,
  input  logic [XLEN-1:0]  i_b_data,
  output logic             o_b_ready,
  input  logic [4:0]       i_Rnum1,
  input  logic [4:0]       i_Rnum2,
  output logic             o_hazard,
  output logic             o_Wen,
  output logic [4:0]       o_Wnum,
  output logic [XLEN-1:0]  o_Wd,
  output logic [N_REG-1:0] o_busy
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  // Handshakes: a transfer happens on a source in any cycle where valid && ready.
  // Ready outputs are combinational from inputs and state and never look at
  // their own valid, so a producer may hold valid while waiting.

  logic [N_REG-1:0] busy;
  logic [N_REG-1:0] busy_next;
  logic [CW-1:0]    starve_cnt;
  logic             starved;
  logic             a_force;
  logic             a_fire;
  logic             b_fire;
  logic             iss_fire;
  logic             w_fire;
  logic [4:0]       w_rd;
  logic [XLEN-1:0]  w_data;

  // A is eligible for a forced win only once it has waited the full budget
  // and is not blocked behind a pending long-latency write to its register.
  assign starved     = (starve_cnt == CW'(STARVE_MAX)) && !busy[i_a_rd];
  assign a_force     = i_a_valid && starved;
  assign o_b_ready   = !a_force;
  assign o_a_ready   = !busy[i_a_rd] && (!i_b_valid || starved);
  assign o_iss_ready = !busy[i_iss_rd];

  assign a_fire   = i_a_valid && o_a_ready;
  assign b_fire   = i_b_valid && o_b_ready;
  assign iss_fire = i_iss_valid && o_iss_ready;
  assign w_fire   = a_fire || b_fire;
  assign w_rd     = a_fire ? i_a_rd : i_b_rd;
  assign w_data   = a_fire ? i_a_data : i_b_data;

  assign o_hazard = ((i_Rnum1 != 5'd0) && busy[i_Rnum1]) ||
                    ((i_Rnum2 != 5'd0) && busy[i_Rnum2]);
  assign o_busy   = busy;

  // Clear first, then set, so an issue to the same register wins.
  always_comb begin
    busy_next = busy;
    if (b_fire) busy_next[i_b_rd] = 1'b0;
    if (iss_fire) busy_next[i_iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      busy       <= '0;
      starve_cnt <= '0;
    end else begin
      busy <= busy_next;
      if (!i_a_valid || a_fire) starve_cnt <= '0;
      else if (starve_cnt != CW'(STARVE_MAX)) starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Writes to x0 complete the handshake but never reach the register file.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_Wen  <= 1'b0;
      o_Wnum <= '0;
      o_Wd   <= '0;
    end else begin
      o_Wen <= w_fire && (w_rd != 5'd0);
      if (w_fire && (w_rd != 5'd0)) begin
        o_Wnum <= w_rd;
        o_Wd   <= w_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: every accepted cycle pushes the expected
// write-port state, which is popped and compared one clock later.
module tb_writeback_arbiter;
  localparam int XLEN = 32;
  localparam int W    = 1 + 5 + XLEN;

  logic            i_clk;
  logic            i_rstn;
  logic            i_iss_valid;
  logic [4:0]      i_iss_rd;
  logic            o_iss_ready;
  logic            i_a_valid;
  logic [4:0]      i_a_rd;
  logic [XLEN-1:0] i_a_data;
  logic            o_a_ready;
  logic            i_b_valid;
  logic [4:0]      i_b_rd;
  logic [XLEN-1:0] i_b_data;
  logic            o_b_ready;
  logic [4:0]      i_Rnum1;
  logic [4:0]      i_Rnum2;
  logic            o_hazard;
  logic            o_Wen;
  logic [4:0]      o_Wnum;
  logic [XLEN-1:0] o_Wd;
  logic [31:0]     o_busy;

  logic [W-1:0]    exp_q[$];
  logic [4:0]      m_wnum;
  logic [XLEN-1:0] m_wd;
  int              passed;
  int              total;

  writeback_arbiter dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_iss_valid(i_iss_valid), .i_iss_rd(i_iss_rd), .o_iss_ready(o_iss_ready),
    .i_a_valid(i_a_valid), .i_a_rd(i_a_rd), .i_a_data(i_a_data), .o_a_ready(o_a_ready),
    .i_b_valid(i_b_valid), .i_b_rd(i_b_rd), .i_b_data(i_b_data), .o_b_ready(o_b_ready),
    .i_Rnum1(i_Rnum1), .i_Rnum2(i_Rnum2), .o_hazard(o_hazard),
    .o_Wen(o_Wen), .o_Wnum(o_Wnum), .o_Wd(o_Wd), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic wen, input logic [4:0] rd, input logic [XLEN-1:0] data);
    if (wen) begin
      m_wnum = rd;
      m_wd   = data;
    end
    exp_q.push_back({wen, m_wnum, m_wd});
  endtask

  task automatic push_idle();
    push(1'b0, 5'd0, '0);
  endtask

  // Inputs settle one time unit after the edge; checks happen mid-cycle.
  task automatic settle();
    #4;
  endtask

  task automatic next_cycle();
    logic [W-1:0] e;
    @(posedge i_clk);
    #1;
    chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("w_en", 64'(o_Wen), 64'(e[W-1]));
      chk("w_num", 64'(o_Wnum), 64'(e[W-2 -: 5]));
      chk("w_data", 64'(o_Wd), 64'(e[XLEN-1:0]));
    end
  endtask

  initial begin
    passed = 0; total = 0; m_wnum = '0; m_wd = '0;
    i_rstn = 1'b0; i_iss_valid = 1'b0; i_iss_rd = '0;
    i_a_valid = 1'b0; i_a_rd = '0; i_a_data = '0;
    i_b_valid = 1'b0; i_b_rd = '0; i_b_data = '0;
    i_Rnum1 = '0; i_Rnum2 = '0;

    #2;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_wen", 64'(o_Wen), 64'd0);
    chk("rst_wnum", 64'(o_Wnum), 64'd0);
    chk("rst_wd", 64'(o_Wd), 64'd0);
    chk("rst_a_ready", 64'(o_a_ready), 64'd1);
    chk("rst_b_ready", 64'(o_b_ready), 64'd1);
    chk("rst_iss_ready", 64'(o_iss_ready), 64'd1);
    chk("rst_hazard", 64'(o_hazard), 64'd0);
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;

    // A alone
    i_a_valid = 1'b1; i_a_rd = 5'd5; i_a_data = 32'hDEADBEEF;
    settle();
    chk("a_only_ready", 64'(o_a_ready), 64'd1);
    push(1'b1, 5'd5, 32'hDEADBEEF);
    next_cycle();
    i_a_valid = 1'b0;
    settle();
    push_idle();
    next_cycle();

    // Collision: B first, then A
    i_a_valid = 1'b1; i_a_rd = 5'd3; i_a_data = 32'h33;
    i_b_valid = 1'b1; i_b_rd = 5'd7; i_b_data = 32'h77;
    settle();
    chk("coll_b_ready", 64'(o_b_ready), 64'd1);
    chk("coll_a_ready", 64'(o_a_ready), 64'd0);
    push(1'b1, 5'd7, 32'h77);
    next_cycle();
    i_b_valid = 1'b0;
    settle();
    chk("coll_a_ready2", 64'(o_a_ready), 64'd1);
    push(1'b1, 5'd3, 32'h33);
    next_cycle();
    i_a_valid = 1'b0;
    settle();
    push_idle();
    next_cycle();

    // Starvation: A held against continuous B
    i_a_valid = 1'b1; i_a_rd = 5'd2; i_a_data = 32'h22;
    i_b_valid = 1'b1; i_b_rd = 5'd8;
    for (int k = 1; k <= 4; k++) begin
      i_b_data = 32'h80 + 32'(k);
      settle();
      chk("starve_a_blocked", 64'(o_a_ready), 64'd0);
      chk("starve_b_ready", 64'(o_b_ready), 64'd1);
      push(1'b1, 5'd8, 32'h80 + 32'(k));
      next_cycle();
    end
    i_b_data = 32'h85;
    settle();
    chk("starve_a_forced", 64'(o_a_ready), 64'd1);
    chk("starve_b_held", 64'(o_b_ready), 64'd0);
    push(1'b1, 5'd2, 32'h22);
    next_cycle();
    i_a_valid = 1'b0; i_b_valid = 1'b0;
    settle();
    chk("starve_cnt_clear", 64'(dut.starve_cnt), 64'd0);
    push_idle();
    next_cycle();

    // Scoreboard on rd 9
    i_iss_valid = 1'b1; i_iss_rd = 5'd9;
    settle();
    chk("iss9_ready", 64'(o_iss_ready), 64'd1);
    push_idle();
    next_cycle();
    i_Rnum2 = 5'd9;
    i_a_valid = 1'b1; i_a_rd = 5'd9; i_a_data = 32'h99;
    settle();
    chk("busy9_set", 64'(o_busy), 64'h200);
    chk("hazard9", 64'(o_hazard), 64'd1);
    chk("a9_blocked", 64'(o_a_ready), 64'd0);
    chk("iss9_again", 64'(o_iss_ready), 64'd0);
    push_idle();
    next_cycle();
    i_a_valid = 1'b0; i_iss_valid = 1'b0;
    i_b_valid = 1'b1; i_b_rd = 5'd9; i_b_data = 32'h9B;
    settle();
    chk("b9_ready", 64'(o_b_ready), 64'd1);
    chk("hazard_no_bypass", 64'(o_hazard), 64'd1);
    push(1'b1, 5'd9, 32'h9B);
    next_cycle();
    i_b_valid = 1'b0;
    settle();
    chk("busy9_clear", 64'(o_busy), 64'd0);
    chk("hazard9_clear", 64'(o_hazard), 64'd0);
    push_idle();
    next_cycle();
    i_Rnum2 = 5'd0;

    // Set and clear of rd 11 together: set wins; B to idle register still written
    i_iss_valid = 1'b1; i_iss_rd = 5'd11;
    i_b_valid = 1'b1; i_b_rd = 5'd11; i_b_data = 32'hB1;
    settle();
    chk("b11_ready", 64'(o_b_ready), 64'd1);
    chk("iss11_ready", 64'(o_iss_ready), 64'd1);
    push(1'b1, 5'd11, 32'hB1);
    next_cycle();
    i_iss_valid = 1'b0; i_b_data = 32'hB2;
    settle();
    chk("busy11_set_wins", 64'(o_busy), 64'h800);
    push(1'b1, 5'd11, 32'hB2);
    next_cycle();
    i_b_valid = 1'b0;
    settle();
    chk("busy11_clear", 64'(o_busy), 64'd0);
    push_idle();
    next_cycle();

    // x0 result and mid-cycle reset
    i_b_valid = 1'b1; i_b_rd = 5'd0; i_b_data = 32'h1;
    settle();
    chk("b0_ready", 64'(o_b_ready), 64'd1);
    push_idle();
    next_cycle();
    i_b_valid = 1'b0;
    i_iss_valid = 1'b1; i_iss_rd = 5'd4;
    settle();
    chk("iss4_ready", 64'(o_iss_ready), 64'd1);
    push_idle();
    next_cycle();
    i_iss_valid = 1'b0;
    i_a_valid = 1'b1; i_a_rd = 5'd6; i_a_data = 32'h66;
    #2;
    chk("busy4_set", 64'(o_busy), 64'h10);
    chk("a6_ready", 64'(o_a_ready), 64'd1);
    #1;
    i_rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_wen", 64'(o_Wen), 64'd0);
    chk("mid_rst_wnum", 64'(o_Wnum), 64'd0);
    chk("mid_rst_wd", 64'(o_Wd), 64'd0);
    chk("mid_rst_iss_ready", 64'(o_iss_ready), 64'd1);
    chk("mid_rst_b_ready", 64'(o_b_ready), 64'd1);
    @(posedge i_clk);
    #1;
    chk("rst_discard_wen", 64'(o_Wen), 64'd0);
    chk("rst_discard_wnum", 64'(o_Wnum), 64'd0);
    chk("rst_discard_busy", 64'(o_busy), 64'd0);
    i_a_valid = 1'b0;
    i_rstn = 1'b1;
    m_wnum = '0; m_wd = '0;

    // Recovery after reset
    i_a_valid = 1'b1; i_a_rd = 5'd1; i_a_data = 32'h11;
    settle();
    chk("recover_a_ready", 64'(o_a_ready), 64'd1);
    push(1'b1, 5'd1, 32'h11);
    next_cycle();
    i_a_valid = 1'b0;
    settle();
    push_idle();
    next_cycle();

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
